xillybus_mem_bridge: RTL

//  Parametrised successor to the fixed 8-bit/32-entry seekable mem stream backing. Serves one Xillybus

---
 rtl/xillybus_mem_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/xillybus_mem_bridge.sv
// Xillybus seekable (mem) stream bridge over a 2**ADDR_W x DATA_W RAM, with a second application port.
// Optional feature macro: XMEM_DIRTY_EN (per-entry dirty bits for host writes).
module xillybus_mem_bridge #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_addr_upd,
  input  logic                   w_open,
  input  logic                   w_wren,
  input  logic [DATA_W-1:0]      w_data,
  output logic                   w_full,
  input  logic                   r_open,
  input  logic                   r_rden,
  output logic [DATA_W-1:0]      r_data,
  output logic                   r_empty,
  output logic                   r_eof,
  input  logic [ADDR_W-1:0]      app_addr,
  input  logic                   app_we,
  input  logic [DATA_W-1:0]      app_wdata,
  output logic [DATA_W-1:0]      app_rdata,
  output logic                   app_collide,
`ifdef XMEM_DIRTY_EN
  input  logic [(2**ADDR_W)-1:0] dirty_clr,
  output logic [(2**ADDR_W)-1:0] dirty,
`endif
  output logic [15:0]            drop_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE} state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d;
  logic                rd_end, rd_end_d, wr_end, wr_end_d;
  logic                open_q, any_open, open_rise;
  logic                rd_fire, wr_go, host_we, wr_drop, app_wr, collide_d;
  logic [ADDR_W-1:0]   pf_addr;
  logic [DATA_W-1:0]   pf, pf_d;
  logic                r_empty_d, r_eof_d, w_full_d;

  // Next-state, pointer and prefetch logic
  always_comb begin
    state_d   = state;
    rd_ptr_d  = rd_ptr;
    wr_ptr_d  = wr_ptr;
    rd_end_d  = rd_end;
    wr_end_d  = wr_end;
    any_open  = r_open | w_open;
    open_rise = any_open & ~open_q;
    rd_fire   = (state == ACTIVE) && !mem_addr_upd && r_rden && !r_empty;
    wr_go     = (state == ACTIVE) && !mem_addr_upd && w_wren && !w_full;
    host_we   = wr_go && !wr_end && !bus_rst;
    wr_drop   = wr_go && wr_end;
    collide_d = host_we && app_we && (app_addr == wr_ptr);
    app_wr    = app_we && !collide_d && !bus_rst;

    case (state)
      IDLE: begin
        if (open_rise) begin
          state_d  = SETTLE;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          rd_end_d = 1'b0;
          wr_end_d = 1'b0;
        end
      end
      SETTLE: state_d = ACTIVE;
      ACTIVE: begin
        if (rd_fire) begin
          if (WRAP == 1'b0 && rd_ptr == LAST) rd_end_d = 1'b1;
          else                                rd_ptr_d = rd_ptr + ADDR_W'(1);
        end
        if (host_we) begin
          if (WRAP == 1'b0 && wr_ptr == LAST) wr_end_d = 1'b1;
          else                                wr_ptr_d = wr_ptr + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_addr_upd) begin
      state_d  = SETTLE;
      rd_ptr_d = mem_addr;
      wr_ptr_d = mem_addr;
      rd_end_d = 1'b0;
      wr_end_d = 1'b0;
    end
    if (!any_open) state_d = IDLE;

    // Prefetch always tracks the next read address; fresh writes bypass the RAM
    pf_addr = rd_ptr_d;
    pf_d    = mem[pf_addr];
    if (app_wr && app_addr == pf_addr) pf_d = app_wdata;
    if (host_we && wr_ptr == pf_addr)  pf_d = w_data;

    r_empty_d = !(state_d == ACTIVE && !rd_end_d);
    r_eof_d   = (state_d == ACTIVE) && rd_end_d;
    w_full_d  = (state_d != ACTIVE);
  end

  // State and output registers
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      rd_end      <= 1'b0;
      wr_end      <= 1'b0;
      open_q      <= 1'b0;
      pf          <= '0;
      r_data      <= '0;
      r_empty     <= 1'b1;
      r_eof       <= 1'b0;
      w_full      <= 1'b1;
      app_rdata   <= '0;
      app_collide <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_d;
      rd_ptr      <= rd_ptr_d;
      wr_ptr      <= wr_ptr_d;
      rd_end      <= rd_end_d;
      wr_end      <= wr_end_d;
      open_q      <= any_open;
      pf          <= pf_d;
      r_empty     <= r_empty_d;
      r_eof       <= r_eof_d;
      w_full      <= w_full_d;
      app_rdata   <= mem[app_addr];
      app_collide <= collide_d;
      if (rd_fire) r_data <= pf;
      if (wr_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // RAM array: not reset; host write wins an address clash with the app port
  always_ff @(posedge bus_clk) begin
    if (host_we) mem[wr_ptr] <= w_data;
    if (app_wr)  mem[app_addr] <= app_wdata;
  end

`ifdef XMEM_DIRTY_EN
  logic [DEPTH-1:0] dirty_set;

  always_comb begin
    dirty_set = '0;
    if (host_we) dirty_set = DEPTH'(1) << wr_ptr;
  end

  // Set beats clear in the same cycle
  always_ff @(posedge bus_clk) begin
    if (bus_rst) dirty <= '0;
    else         dirty <= (dirty & ~dirty_clr) | dirty_set;
  end
`endif

endmodule
